child_slot_scheduler: RTL and testbench

Round-robin scheduler that shares one downstream resource among the five child instances of a subtree root module. Each child slot raises a request. The scheduler grants exactly one slot at a time and holds the grant until that slot signals done, drops its request, or exceeds a hold-time watchdog. It then inserts a one-cycle recovery gap and advances the priority pointer. The block sits in the root module beside the child instances, and its one-hot grant vector gates the shared resource.

---
 rtl/child_slot_scheduler.sv | 146 ++++++++++++++
 tb/tb_child_slot_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/child_slot_scheduler.sv
// Round-robin scheduler sharing one downstream resource among the child slots of a subtree root.
// Grants one slot at a time, holds until done/request drop/watchdog, then one dead recovery cycle.
module child_slot_scheduler #(
    parameter int unsigned N_SLOTS  = 5,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_SLOTS-1:0]         req,
    input  logic [N_SLOTS-1:0]         done,
    output logic [N_SLOTS-1:0]         gnt,
    output logic [$clog2(N_SLOTS)-1:0] gnt_id,
    output logic                       busy,
    output logic                       timeout,
    output logic [CNT_W-1:0]           grant_count
);

    localparam int unsigned IdW   = $clog2(N_SLOTS);
    localparam int unsigned HoldW = $clog2(MAX_HOLD);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StGrant   = 2'd1;
    localparam logic [1:0] StRecover = 2'd2;

    localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);
    localparam logic [IdW-1:0]   LastId   = IdW'(N_SLOTS - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    logic [1:0]         state_q, state_d;
    logic [IdW-1:0]     ptr_q, ptr_d;
    logic [N_SLOTS-1:0] gnt_q, gnt_d;
    logic [IdW-1:0]     gnt_id_q, gnt_id_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;
    logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]   grant_count_q, grant_count_d;

    logic               win_found;
    logic [IdW-1:0]     win_id;
    logic [IdW-1:0]     scan_idx;
    int unsigned        scan_sum;
    logic               rel_normal;
    logic               rel_watchdog;

    // Rotating priority scan: first requester at or after ptr, wrapping modulo N_SLOTS.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_sum  = 0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            scan_sum = int'(ptr_q) + i;
            if (scan_sum >= N_SLOTS) begin
                scan_sum = scan_sum - N_SLOTS;
            end
            scan_idx = IdW'(scan_sum);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    // Only the granted slot's done/req matter; a normal release wins over the watchdog.
    always_comb begin
        rel_normal   = done[gnt_id_q] | ~req[gnt_id_q];
        rel_watchdog = (hold_cnt_q == HoldLast);
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gnt_d         = gnt_q;
        gnt_id_d      = gnt_id_q;
        busy_d        = busy_q;
        timeout_d     = 1'b0;
        hold_cnt_d    = hold_cnt_q;
        grant_count_d = grant_count_q;

        case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d    = StGrant;
                    gnt_d      = {{(N_SLOTS-1){1'b0}}, 1'b1} << win_id;
                    gnt_id_d   = win_id;
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                    if (grant_count_q != CntMax) begin
                        grant_count_d = grant_count_q + 1'b1;
                    end
                end
            end
            StGrant: begin
                if (rel_normal || rel_watchdog) begin
                    state_d   = StRecover;
                    ptr_d     = (gnt_id_q == LastId) ? '0 : gnt_id_q + 1'b1;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    busy_d    = 1'b0;
                    timeout_d = ~rel_normal;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StRecover: begin
                state_d = StIdle;
            end
            default: begin
                state_d  = StIdle;
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            gnt_q         <= '0;
            gnt_id_q      <= '0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
            hold_cnt_q    <= '0;
            grant_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            gnt_id_q      <= gnt_id_d;
            busy_q        <= busy_d;
            timeout_q     <= timeout_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_count_q <= grant_count_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_id      = gnt_id_q;
    assign busy        = busy_q;
    assign timeout     = timeout_q;
    assign grant_count = grant_count_q;

endmodule

// File: tb/tb_child_slot_scheduler.sv
// Self-checking bench for child_slot_scheduler: directed scenarios plus random traffic,
// all compared against a tenure-level behavioural model; a CNT_W=2 copy checks saturation.
module tb_child_slot_scheduler;

    localparam int N  = 5;
    localparam int MH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] req = '0;
    logic [4:0] done = '0;

    logic [4:0]  gnt, sat_gnt;
    logic [2:0]  gnt_id, sat_gnt_id;
    logic        busy, timeout, sat_busy, sat_timeout;
    logic [15:0] grant_count;
    logic [1:0]  sat_count;

    always #5 clk = ~clk;

    child_slot_scheduler #(.N_SLOTS(5), .MAX_HOLD(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout),
        .grant_count(grant_count)
    );

    child_slot_scheduler #(.N_SLOTS(5), .MAX_HOLD(16), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(sat_gnt), .gnt_id(sat_gnt_id), .busy(sat_busy), .timeout(sat_timeout),
        .grant_count(sat_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: owner slot (-1 = none), cycles held so far, pending recovery gap, pointer, grants.
    int m_owner = -1;
    int m_held  = 0;
    int m_gap   = 0;
    int m_ptr   = 0;
    int m_count = 0;
    bit m_timeout = 1'b0;
    int grant_log[$];

    wire [27:0] act = {gnt, gnt_id, busy, timeout, grant_count, sat_count};

    function automatic void model_reset();
        m_owner = -1; m_held = 0; m_gap = 0; m_ptr = 0; m_count = 0; m_timeout = 1'b0;
        grant_log.delete();
    endfunction

    function automatic void model_release(bit wd);
        m_ptr     = (m_owner + 1) % N;
        m_owner   = -1;
        m_gap     = 1;
        m_timeout = wd;
    endfunction

    function automatic void model_step();
        bit found;
        m_timeout = 1'b0;
        if (m_owner >= 0) begin
            if (done[m_owner] || !req[m_owner]) model_release(1'b0);
            else if (m_held == MH) model_release(1'b1);
            else m_held++;
        end else if (m_gap != 0) begin
            m_gap = 0;
        end else if (req != 5'b0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && req[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    m_owner = (m_ptr + k) % N;
                end
            end
            m_held = 1;
            m_count++;
            grant_log.push_back(m_owner);
        end
    endfunction

    function automatic logic [27:0] model_out();
        logic [4:0] g;
        logic [2:0] id;
        g = '0;
        id = '0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            id = 3'(m_owner);
        end
        return {g, id, (m_owner >= 0), m_timeout,
                16'(m_count > 65535 ? 65535 : m_count), 2'(m_count > 3 ? 3 : m_count)};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req = '0;
        done = '0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (act !== 28'h0) begin
            n_err++; $display("FAIL reset_initial: got %h want 0", act);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req = 5'b00100;
        tick();
        n_cmp++;
        if ({gnt, gnt_id, grant_count} !== {5'b00100, 3'd2, 16'd1}) begin
            n_err++;
            $display("FAIL reset_first_grant: got gnt=%b id=%0d cnt=%0d want 00100/2/1",
                     gnt, gnt_id, grant_count);
        end
        tick();
        n_cmp++;
        if (act !== model_out()) begin
            n_err++; $display("FAIL reset_hold: got %h want %h", act, model_out());
        end
        // Assert reset between edges and check outputs clear with no clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (act !== 28'h0) begin
            n_err++; $display("FAIL reset_async: got %h want 0", act);
        end
        model_reset();
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rotation();
        int exp_order[6] = '{0, 1, 2, 3, 4, 0};
        int c = 0;
        apply_reset();
        req = 5'b11111;
        while (grant_log.size() < 6 && c < 60) begin
            done = (m_owner >= 0 && m_held == 2) ? 5'(1 << m_owner) : 5'b0;
            tick();
            c++;
            n_cmp++;
            if (act !== model_out()) begin
                n_err++; $display("FAIL rotation cyc %0d: got %h want %h", c, act, model_out());
            end
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (i >= grant_log.size() || grant_log[i] != exp_order[i]) begin
                n_err++;
                $display("FAIL rotation_order[%0d]: got %0d want %0d", i,
                         (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
            end
        end
        n_cmp++;
        if (grant_count !== 16'd6 || sat_count !== 2'd3) begin
            n_err++;
            $display("FAIL rotation_count: got %0d/%0d want 6/3", grant_count, sat_count);
        end
        done = '0;
    endtask

    task automatic test_watchdog();
        int first_run = 0, to_cyc = -1, regrant_cyc = -1;
        bit first_done = 1'b0;
        logic [4:0] prev = '0;
        apply_reset();
        req = 5'b01000;
        for (int c = 1; c <= 40; c++) begin
            tick();
            n_cmp++;
            if (act !== model_out()) begin
                n_err++; $display("FAIL watchdog cyc %0d: got %h want %h", c, act, model_out());
            end
            if (!first_done && gnt == 5'b01000) first_run++;
            if (first_run > 0 && gnt == 5'b0) first_done = 1'b1;
            if (timeout === 1'b1 && to_cyc < 0) to_cyc = c;
            if (to_cyc > 0 && regrant_cyc < 0 && prev == 5'b0 && gnt == 5'b01000) regrant_cyc = c;
            prev = gnt;
        end
        n_cmp++;
        if (first_run != 16) begin
            n_err++; $display("FAIL watchdog_len: got %0d want 16", first_run);
        end
        n_cmp++;
        if (to_cyc != 17 || regrant_cyc != 19) begin
            n_err++;
            $display("FAIL watchdog_timing: got timeout@%0d regrant@%0d want 17/19",
                     to_cyc, regrant_cyc);
        end
    endtask

    task automatic test_collision();
        int to_seen = 0;
        apply_reset();
        req = 5'b01000;
        for (int c = 1; c <= 24; c++) begin
            done = (m_owner == 3 && m_held == 16) ? 5'b01000 : 5'b0;
            tick();
            n_cmp++;
            if (act !== model_out()) begin
                n_err++; $display("FAIL collision cyc %0d: got %h want %h", c, act, model_out());
            end
            if (timeout === 1'b1) to_seen++;
        end
        n_cmp++;
        if (to_seen != 0) begin
            n_err++; $display("FAIL collision_timeout: got %0d pulses want 0", to_seen);
        end
        done = '0;
    endtask

    task automatic test_ignored();
        apply_reset();
        req = 5'b00010;
        tick();
        for (int c = 0; c < 4; c++) begin
            done = (c % 2 == 0) ? 5'b01000 : 5'b0;
            req[4] = ~req[4];
            tick();
            n_cmp++;
            if (gnt !== 5'b00010 || act !== model_out()) begin
                n_err++; $display("FAIL ignored_hold cyc %0d: got gnt=%b want 00010", c, gnt);
            end
        end
        done = '0;
        req = 5'b10000;
        tick();
        n_cmp++;
        if (gnt !== 5'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL ignored_release: got gnt=%b busy=%b want 0/0", gnt, busy);
        end
        req = 5'b10011;
        tick();
        tick();
        n_cmp++;
        if (gnt !== 5'b10000 || gnt_id !== 3'd4) begin
            n_err++; $display("FAIL ignored_ptr: got gnt=%b id=%0d want 10000/4", gnt, gnt_id);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = 5'($urandom);
            done = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'b0;
            if (c == 300) begin
                #2;
                rst_n = 1'b0;
                #1;
                n_cmp++;
                if (act !== 28'h0) begin
                    n_err++; $display("FAIL random_reset: got %h want 0", act);
                end
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            tick();
            n_cmp++;
            if (act !== model_out()) begin
                n_err++; $display("FAIL random cyc %0d: got %h want %h", c, act, model_out());
            end
        end
        req = '0;
        done = '0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_watchdog();
        test_collision();
        test_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
